key_conditioner: RTL and testbench

KEY_CONDITIONER -- requirements
Module: key_conditioner

---
 rtl/key_conditioner.sv | 116 +++++++++++
 tb/tb_key_conditioner.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/key_conditioner.sv
// key_conditioner: per-key synchronizer, debouncer, edge strobes and auto-repeat
// for active-low pushbuttons. Each key is handled by an independent channel.
module key_conditioner #(
    parameter int N_KEYS       = 4,
    parameter int DB_CYCLES    = 500000,
    parameter int REPEAT_DELAY = 25000000,
    parameter int REPEAT_RATE  = 5000000
) (
    input  logic              CLOCK_50,
    input  logic              Reset,
    input  logic [N_KEYS-1:0] KEY,
    output logic [N_KEYS-1:0] pressed,
    output logic [N_KEYS-1:0] press_pulse,
    output logic [N_KEYS-1:0] release_pulse,
    output logic [N_KEYS-1:0] repeat_pulse
);

    localparam int DBW      = $clog2(DB_CYCLES + 1);
    localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int HW       = $clog2(HOLD_MAX + 1);

    // Terminal counts: the edge on which the counter would reach its limit.
    localparam logic [DBW-1:0] DB_LAST    = DBW'(DB_CYCLES - 1);
    localparam logic [HW-1:0]  DELAY_LAST = HW'(REPEAT_DELAY - 1);
    localparam logic [HW-1:0]  RATE_LAST  = HW'(REPEAT_RATE - 1);

    for (genvar i = 0; i < N_KEYS; i++) begin : g_chan
        logic           sync1_q, sync1_d;
        logic           sync2_q, sync2_d;
        logic           acc_q, acc_d;          // accepted raw level, 1 = released
        logic [DBW-1:0] db_cnt_q, db_cnt_d;
        logic           pressed_q, pressed_d;
        logic           press_q, press_d;
        logic           release_q, release_d;
        logic           repeat_q, repeat_d;
        logic [HW-1:0]  hold_q, hold_d;
        logic           in_rate_q, in_rate_d;  // first repeat already issued

        // Next-state logic: synchronize, debounce, derive strobes and auto-repeat.
        always_comb begin
            sync1_d  = KEY[i];
            sync2_d  = sync1_q;
            acc_d    = acc_q;
            db_cnt_d = '0;

            // Count consecutive cycles that disagree with the accepted level;
            // any agreeing cycle throws the partial count away.
            if (sync2_q != acc_q) begin
                if (db_cnt_q == DB_LAST) begin
                    acc_d    = ~acc_q;
                    db_cnt_d = '0;
                end else begin
                    db_cnt_d = db_cnt_q + DBW'(1);
                end
            end else begin
                db_cnt_d = '0;
            end

            pressed_d = ~acc_q;
            press_d   = pressed_d & ~pressed_q;
            release_d = ~pressed_d & pressed_q;

            // Hold counter only runs while the key stays held across this edge,
            // so no repeat can land on the press or release strobe cycle.
            repeat_d  = 1'b0;
            hold_d    = '0;
            in_rate_d = 1'b0;
            if (pressed_q && pressed_d) begin
                in_rate_d = in_rate_q;
                if (hold_q == (in_rate_q ? RATE_LAST : DELAY_LAST)) begin
                    repeat_d  = 1'b1;
                    hold_d    = '0;
                    in_rate_d = 1'b1;
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end else begin
                hold_d    = '0;
                in_rate_d = 1'b0;
            end
        end

        // State registers with synchronous reset to the released condition.
        always_ff @(posedge CLOCK_50) begin
            if (Reset) begin
                sync1_q   <= 1'b1;
                sync2_q   <= 1'b1;
                acc_q     <= 1'b1;
                db_cnt_q  <= '0;
                pressed_q <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                repeat_q  <= 1'b0;
                hold_q    <= '0;
                in_rate_q <= 1'b0;
            end else begin
                sync1_q   <= sync1_d;
                sync2_q   <= sync2_d;
                acc_q     <= acc_d;
                db_cnt_q  <= db_cnt_d;
                pressed_q <= pressed_d;
                press_q   <= press_d;
                release_q <= release_d;
                repeat_q  <= repeat_d;
                hold_q    <= hold_d;
                in_rate_q <= in_rate_d;
            end
        end

        assign pressed[i]       = pressed_q;
        assign press_pulse[i]   = press_q;
        assign release_pulse[i] = release_q;
        assign repeat_pulse[i]  = repeat_q;
    end

endmodule

// File: tb/tb_key_conditioner.sv
// Directed + randomized bench for key_conditioner with a behavioural model.
module tb_key_conditioner;

    localparam int N    = 4;
    localparam int DB   = 4;
    localparam int RD   = 10;
    localparam int RATE = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] key;
    logic [N-1:0] pressed, press_pulse, release_pulse, repeat_pulse;

    int checks = 0;
    int errors = 0;

    // Behavioural model state (per key, "held" sense: 1 = pressed)
    int edge_n = 0;
    bit m_d1 [N];
    bit m_d2 [N];
    bit m_acc [N];
    int m_run [N];
    bit m_pressed [N];
    int m_pedge [N];
    logic [N-1:0] e_pressed, e_press, e_release, e_repeat;

    key_conditioner #(
        .N_KEYS(N), .DB_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_RATE(RATE)
    ) dut (
        .CLOCK_50(clk), .Reset(rst), .KEY(key),
        .pressed(pressed), .press_pulse(press_pulse),
        .release_pulse(release_pulse), .repeat_pulse(repeat_pulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance the model by one rising edge with the inputs seen at that edge.
    task automatic model(input logic r, input logic [N-1:0] k);
        for (int i = 0; i < N; i++) begin
            if (r) begin
                m_d1[i] = 1'b0; m_d2[i] = 1'b0; m_acc[i] = 1'b0;
                m_run[i] = 0; m_pressed[i] = 1'b0;
                e_pressed[i] = 1'b0; e_press[i] = 1'b0;
                e_release[i] = 1'b0; e_repeat[i] = 1'b0;
            end else begin
                bit old_p, new_p;
                old_p = m_pressed[i];
                new_p = m_acc[i];
                e_pressed[i] = new_p;
                e_press[i]   = new_p & ~old_p;
                e_release[i] = ~new_p & old_p;
                if (e_press[i]) m_pedge[i] = edge_n;
                e_repeat[i] = old_p && new_p && (edge_n - m_pedge[i] >= RD)
                              && ((edge_n - m_pedge[i] - RD) % RATE == 0);
                m_pressed[i] = new_p;
                if (m_d2[i] != m_acc[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DB) begin
                        m_acc[i] = ~m_acc[i];
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
                m_d2[i] = m_d1[i];
                m_d1[i] = ~k[i];
            end
        end
        edge_n++;
    endtask

    task automatic step(input logic r, input logic [N-1:0] k);
        rst = r;
        key = k;
        @(posedge clk);
        #1;
        model(r, k);
        check("pressed", int'(pressed), int'(e_pressed));
        check("press_pulse", int'(press_pulse), int'(e_press));
        check("release_pulse", int'(release_pulse), int'(e_release));
        check("repeat_pulse", int'(repeat_pulse), int'(e_repeat));
    endtask

    initial begin
        int idx0, idx3, cnt, rep_cnt, rel_cnt, found;
        logic [N-1:0] kv;

        // Reset
        for (int c = 0; c < 3; c++) step(1'b1, 4'hF);
        check("reset_outputs", int'({pressed, press_pulse, release_pulse, repeat_pulse}), 0);

        // Clean press on KEY[0]: step index j corresponds to edge j
        for (int j = 0; j <= 7; j++) begin
            step(1'b0, 4'b1110);
            if (j == 5) check("k0_not_yet", int'(pressed[0]), 0);
            if (j == 6) begin
                check("k0_pressed_e6", int'(pressed[0]), 1);
                check("k0_press_e6", int'(press_pulse[0]), 1);
            end
            if (j == 7) check("k0_press_e7", int'(press_pulse[0]), 0);
        end
        for (int j = 0; j < 10; j++) step(1'b0, 4'hF);

        // Short glitch on KEY[1]: nothing accepted
        cnt = 0;
        for (int j = 0; j < 15; j++) begin
            step(1'b0, (j < 3) ? 4'b1101 : 4'hF);
            cnt += int'(pressed[1]) + int'(press_pulse[1]) + int'(release_pulse[1]);
        end
        check("k1_glitch_ignored", cnt, 0);

        // Long hold on KEY[2] with auto-repeat
        found = 0;
        for (int j = 0; j < 20 && found == 0; j++) begin
            step(1'b0, 4'b1011);
            if (press_pulse[2]) found = 1;
        end
        check("k2_accept_seen", found, 1);
        rep_cnt = 0; rel_cnt = 0;
        for (int j = 0; j < 23; j++) begin
            step(1'b0, 4'b1011);
            rep_cnt += int'(repeat_pulse[2]);
        end
        for (int j = 0; j < 20; j++) begin
            step(1'b0, 4'hF);
            rep_cnt += int'(repeat_pulse[2]);
            rel_cnt += int'(release_pulse[2]);
        end
        check("k2_repeat_count", rep_cnt, 7);
        check("k2_release_count", rel_cnt, 1);

        // Reset mid-debounce on KEY[3], key kept low afterwards
        step(1'b0, 4'b0111);
        step(1'b0, 4'b0111);
        step(1'b1, 4'b0111);
        idx3 = -1; cnt = 0;
        for (int j = 0; j < 12; j++) begin
            step(1'b0, 4'b0111);
            cnt += int'(press_pulse[3]);
            if (press_pulse[3] && idx3 < 0) idx3 = j;
        end
        check("k3_after_reset_idx", idx3, 6);
        check("k3_after_reset_cnt", cnt, 1);
        for (int j = 0; j < 12; j++) step(1'b0, 4'hF);

        // Simultaneous press on KEY[0] and KEY[3]
        idx0 = -1; idx3 = -1; cnt = 0;
        for (int j = 0; j < 10; j++) begin
            step(1'b0, 4'b0110);
            if (press_pulse[0] && idx0 < 0) idx0 = j;
            if (press_pulse[3] && idx3 < 0) idx3 = j;
            cnt += int'(press_pulse[1]) + int'(press_pulse[2]);
        end
        check("dual_k0_idx", idx0, 6);
        check("dual_k3_idx", idx3, 6);
        check("dual_others", cnt, 0);
        for (int j = 0; j < 12; j++) step(1'b0, 4'hF);

        // Bounce 0,1,0,0,1 then steady 0 on KEY[1]
        idx0 = -1; cnt = 0;
        for (int j = 0; j < 20; j++) begin
            kv = 4'hF;
            kv[1] = (j == 1 || j == 4) ? 1'b1 : 1'b0;
            step(1'b0, kv);
            cnt += int'(press_pulse[1]);
            if (press_pulse[1] && idx0 < 0) idx0 = j;
        end
        check("bounce_press_count", cnt, 1);
        check("bounce_press_idx", idx0, 11);
        for (int j = 0; j < 12; j++) step(1'b0, 4'hF);

        // Randomized traffic with occasional resets
        kv = 4'hF;
        for (int j = 0; j < 3000; j++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 3 + 12 * i) == 0) kv[i] = ~kv[i];
            step(($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0, kv);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
